// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared types, constants and width helpers for the CNN datapath
package cnn_pkg;

    localparam int CNN_DATA_WIDTH = 16;

    typedef logic signed [CNN_DATA_WIDTH-1:0] data_t;

    localparam data_t S_MAX = {1'b0, {(CNN_DATA_WIDTH-1){1'b1}}};
    localparam data_t S_MIN = {1'b1, {(CNN_DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_WRITE,
        ST_FINISH
    } pool_state_t;

    // Width for a counter or address covering v values; never below one bit.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    function automatic int in_aw(input int ch, input int h, input int w);
        return clog2_min1(ch * h * w);
    endfunction

    function automatic int out_aw(input int ch, input int h, input int w);
        return clog2_min1(ch * (h / 2) * (w / 2));
    endfunction

endpackage

// File: rtl/maxpool_flatten_if.sv
// rtl/maxpool_flatten_if.sv - control, feature-map read and flattened write bus of the pool stage
interface maxpool_flatten_if #(
    parameter int DATA_WIDTH = 16,
    parameter int IN_AW      = 13,
    parameter int OUT_AW     = 11
);
    logic                         start;
    logic                         busy;
    logic                         done;
    logic [IN_AW-1:0]             in_addr;
    logic                         in_en;
    logic signed [DATA_WIDTH-1:0] in_q;
    logic [OUT_AW-1:0]            out_addr;
    logic                         out_we;
    logic signed [DATA_WIDTH-1:0] out_d;

    modport master (
        input  start, in_q,
        output busy, done, in_addr, in_en, out_addr, out_we, out_d
    );

    modport slave (
        output start, in_q,
        input  busy, done, in_addr, in_en, out_addr, out_we, out_d
    );
endinterface

// File: rtl/maxpool_addr_gen.sv
// rtl/maxpool_addr_gen.sv - window/channel counters and read/write address generation
module maxpool_addr_gen
    import cnn_pkg::*;
#(
    parameter int CHANNELS = 8,
    parameter int IN_H     = 28,
    parameter int IN_W     = 28,
    parameter int IN_AW    = 13,
    parameter int OUT_AW   = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              step_k_i,
    input  logic              step_win_i,
    output logic [IN_AW-1:0]  in_addr_o,
    output logic [OUT_AW-1:0] out_addr_o,
    output logic [1:0]        k_o,
    output logic              last_k_o,
    output logic              last_window_o
);
    localparam int OH   = IN_H / 2;
    localparam int OW   = IN_W / 2;
    localparam int C_W  = clog2_min1(CHANNELS);
    localparam int PR_W = clog2_min1(OH);
    localparam int PC_W = clog2_min1(OW);

    localparam logic [C_W-1:0]  C_LAST  = C_W'(CHANNELS - 1);
    localparam logic [PR_W-1:0] PR_LAST = PR_W'(OH - 1);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(OW - 1);

    logic [C_W-1:0]  c_q,  c_d;
    logic [PR_W-1:0] pr_q, pr_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [1:0]      k_q,  k_d;

    // Next counter values: k steps per read, pc/pr/c advance once per written window.
    always_comb begin
        c_d  = c_q;
        pr_d = pr_q;
        pc_d = pc_q;
        k_d  = k_q;
        if (clear_i) begin
            c_d  = '0;
            pr_d = '0;
            pc_d = '0;
            k_d  = '0;
        end else begin
            if (step_k_i) begin
                k_d = k_q + 2'd1;
            end
            if (step_win_i) begin
                if (pc_q == PC_LAST) begin
                    pc_d = '0;
                    if (pr_q == PR_LAST) begin
                        pr_d = '0;
                        c_d  = (c_q == C_LAST) ? '0 : c_q + 1'b1;
                    end else begin
                        pr_d = pr_q + 1'b1;
                    end
                end else begin
                    pc_d = pc_q + 1'b1;
                end
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            c_q  <= '0;
            pr_q <= '0;
            pc_q <= '0;
            k_q  <= '0;
        end else begin
            c_q  <= c_d;
            pr_q <= pr_d;
            pc_q <= pc_d;
            k_q  <= k_d;
        end
    end

    // k[1] selects the lower row of the window, k[0] the right column.
    assign in_addr_o = IN_AW'(c_q) * IN_AW'(IN_H * IN_W)
                     + (IN_AW'({pr_q, 1'b0}) + IN_AW'(k_q[1])) * IN_AW'(IN_W)
                     + IN_AW'({pc_q, 1'b0}) + IN_AW'(k_q[0]);

    assign out_addr_o = OUT_AW'(c_q) * OUT_AW'(OH * OW)
                      + OUT_AW'(pr_q) * OUT_AW'(OW)
                      + OUT_AW'(pc_q);

    assign k_o           = k_q;
    assign last_k_o      = (k_q == 2'd3);
    assign last_window_o = (c_q == C_LAST) && (pr_q == PR_LAST) && (pc_q == PC_LAST);

endmodule

// File: rtl/maxpool_flatten.sv
// rtl/maxpool_flatten.sv - 2x2/stride-2 signed max-pool with channel-major flatten; MAXPOOL_RELU_EN fuses a ReLU on the output
module maxpool_flatten
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CHANNELS   = 8,
    parameter int IN_H       = 28,
    parameter int IN_W       = 28,
    parameter int LAT        = 2
) (
    input  logic              clk,
    input  logic              reset,
    maxpool_flatten_if.master mp
);
    localparam int IN_AW  = in_aw(CHANNELS, IN_H, IN_W);
    localparam int OUT_AW = out_aw(CHANNELS, IN_H, IN_W);

    pool_state_t state_q, state_d;
    logic [2:0]  wait_q, wait_d;

    logic clear, step_k, step_win;
    logic in_en, out_we, done;
    logic last_k, last_window;
    logic [1:0] k;
    logic [IN_AW-1:0]  in_addr;
    logic [OUT_AW-1:0] out_addr;

    logic [LAT-1:0]               vld_q;
    logic [1:0]                   tag_q [LAT];
    logic signed [DATA_WIDTH-1:0] max_q;
    logic signed [DATA_WIDTH-1:0] out_d;

    maxpool_addr_gen #(
        .CHANNELS (CHANNELS),
        .IN_H     (IN_H),
        .IN_W     (IN_W),
        .IN_AW    (IN_AW),
        .OUT_AW   (OUT_AW)
    ) u_addr_gen (
        .clk           (clk),
        .reset         (reset),
        .clear_i       (clear),
        .step_k_i      (step_k),
        .step_win_i    (step_win),
        .in_addr_o     (in_addr),
        .out_addr_o    (out_addr),
        .k_o           (k),
        .last_k_o      (last_k),
        .last_window_o (last_window)
    );

    // State and drain-counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next state and strobes: four reads, LAT drain cycles, one write per window.
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        clear    = 1'b0;
        step_k   = 1'b0;
        step_win = 1'b0;
        in_en    = 1'b0;
        out_we   = 1'b0;
        done     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mp.start) begin
                    clear   = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                in_en  = 1'b1;
                step_k = 1'b1;
                if (last_k) begin
                    wait_d  = '0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (wait_q == 3'(LAT - 1)) begin
                    state_d = ST_WRITE;
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            ST_WRITE: begin
                out_we   = 1'b1;
                step_win = 1'b1;
                state_d  = last_window ? ST_FINISH : ST_ISSUE;
            end
            ST_FINISH: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read-valid/tag delay line and running max; tag 0 loads so no min-value bias.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                tag_q[i] <= '0;
            end
            max_q <= '0;
        end else begin
            vld_q[0] <= in_en;
            tag_q[0] <= k;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
            if (vld_q[LAT-1]) begin
                if (tag_q[LAT-1] == 2'd0) begin
                    max_q <= mp.in_q;
                end else if (mp.in_q > max_q) begin
                    max_q <= mp.in_q;
                end
            end
        end
    end

    // Output value presented only during WRITE.
    always_comb begin
        out_d = '0;
        if (out_we) begin
`ifdef MAXPOOL_RELU_EN
            out_d = max_q[DATA_WIDTH-1] ? '0 : max_q;
`else
            out_d = max_q;
`endif
        end
    end

    assign mp.in_en    = in_en;
    assign mp.in_addr  = in_addr;
    assign mp.out_we   = out_we;
    assign mp.out_addr = out_addr;
    assign mp.out_d    = out_d;
    assign mp.done     = done;
    assign mp.busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_maxpool_flatten.sv
// tb/tb_maxpool_flatten.sv - scoreboard bench for maxpool_flatten at LAT 2 (main) plus LAT 1 and 4
module tb_maxpool_flatten;
    localparam int CH  = 2;
    localparam int H   = 4;
    localparam int W   = 4;
    localparam int N   = 8;
    localparam int DW  = 16;
    localparam int IAW = 5;
    localparam int OAW = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start_m = 1'b0;
    logic start_a = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [15:0] mem [32];
    logic [15:0] p0 [4];
    logic [15:0] p1 [4];
    logic [15:0] p2 [4];
    logic [18:0] exp_q0 [$];
    logic [18:0] exp_q1 [$];
    logic [18:0] exp_q2 [$];
    int en_cnt [3]   = '{0, 0, 0};
    int we_cnt [3]   = '{0, 0, 0};
    int done_cnt [3] = '{0, 0, 0};
    int done_cyc [3] = '{0, 0, 0};

    int          ramp_exp [8] = '{5, 7, 13, 15, 21, 23, 29, 31};
    logic [15:0] sw_in [8][4];
    logic [15:0] sw_exp [8];

    maxpool_flatten_if #(.DATA_WIDTH(DW), .IN_AW(IAW), .OUT_AW(OAW)) mp0 ();
    maxpool_flatten_if #(.DATA_WIDTH(DW), .IN_AW(IAW), .OUT_AW(OAW)) mp1 ();
    maxpool_flatten_if #(.DATA_WIDTH(DW), .IN_AW(IAW), .OUT_AW(OAW)) mp2 ();

    maxpool_flatten #(.DATA_WIDTH(DW), .CHANNELS(CH), .IN_H(H), .IN_W(W), .LAT(2)) dut (
        .clk(clk), .reset(reset), .mp(mp0.master));
    maxpool_flatten #(.DATA_WIDTH(DW), .CHANNELS(CH), .IN_H(H), .IN_W(W), .LAT(1)) u_lat1 (
        .clk(clk), .reset(reset), .mp(mp1.master));
    maxpool_flatten #(.DATA_WIDTH(DW), .CHANNELS(CH), .IN_H(H), .IN_W(W), .LAT(4)) u_lat4 (
        .clk(clk), .reset(reset), .mp(mp2.master));

    assign mp0.start = start_m;
    assign mp1.start = start_a;
    assign mp2.start = start_a;
    assign mp0.in_q  = p0[1];
    assign mp1.in_q  = p1[0];
    assign mp2.in_q  = p2[3];

    always #5 clk = ~clk;

    // Cycle counter and BRAM read pipelines of each latency.
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        p0[0] <= mp0.in_en ? mem[mp0.in_addr] : 16'hDEAD;
        p1[0] <= mp1.in_en ? mem[mp1.in_addr] : 16'hDEAD;
        p2[0] <= mp2.in_en ? mem[mp2.in_addr] : 16'hDEAD;
        for (int i = 1; i < 4; i++) begin
            p0[i] <= p0[i-1];
            p1[i] <= p1[i-1];
            p2[i] <= p2[i-1];
        end
    end

    task automatic mon_one(input int i, input logic we, input logic [2:0] a, input logic [15:0] d,
                           input logic en, input logic dn);
        logic [18:0] e;
        bit have;
        have = 1'b0;
        e = '0;
        if (en) en_cnt[i]++;
        if (dn) begin
            done_cnt[i]++;
            done_cyc[i] = cyc;
        end
        if (we) begin
            we_cnt[i]++;
            case (i)
                0: if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); have = 1'b1; end
                1: if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); have = 1'b1; end
                default: if (exp_q2.size() > 0) begin e = exp_q2.pop_front(); have = 1'b1; end
            endcase
            checks++;
            if (!have) begin
                errors++;
                $display("FAIL unexpected_write dut%0d: got addr=%0d data=%h, required no write", i, a, d);
            end else if ({a, d} !== e) begin
                errors++;
                $display("FAIL write dut%0d: got addr=%0d data=%h, required addr=%0d data=%h",
                         i, a, d, e[18:16], e[15:0]);
            end
        end
    endtask

    // Monitor: samples all three DUTs mid-cycle and checks writes against the scoreboard.
    always @(negedge clk) begin
        mon_one(0, mp0.out_we, mp0.out_addr, mp0.out_d, mp0.in_en, mp0.done);
        mon_one(1, mp1.out_we, mp1.out_addr, mp1.out_d, mp1.in_en, mp1.done);
        mon_one(2, mp2.out_we, mp2.out_addr, mp2.out_d, mp2.in_en, mp2.done);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic push(input int i, input logic [2:0] a, input logic [15:0] d);
        case (i)
            0: exp_q0.push_back({a, d});
            1: exp_q1.push_back({a, d});
            default: exp_q2.push_back({a, d});
        endcase
    endtask

    task automatic push_ramp(input int i, input int nwin, input int off);
        for (int w = 0; w < nwin; w++) push(i, 3'(w), 16'(ramp_exp[w] + off));
    endtask

    task automatic fill_ramp(input int off);
        for (int a = 0; a < 32; a++) mem[a] = 16'(a + off);
    endtask

    task automatic set_win(input int w, input logic [15:0] v0, input logic [15:0] v1,
                           input logic [15:0] v2, input logic [15:0] v3);
        int base;
        base = (w / 4) * 16 + ((w / 2) % 2) * 8 + (w % 2) * 2;
        mem[base]     = v0;
        mem[base + 1] = v1;
        mem[base + 4] = v2;
        mem[base + 5] = v3;
    endtask

    task automatic pulse(input bit m, input bit a, output int t);
        @(posedge clk);
        #1;
        start_m = m;
        start_a = a;
        t = cyc;
        @(posedge clk);
        #1;
        start_m = 1'b0;
        start_a = 1'b0;
    endtask

    task automatic wait_done(input int i, input int prev);
        int n;
        n = 0;
        while (done_cnt[i] == prev && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (done_cnt[i] == prev) begin
            errors++;
            $display("FAIL done_timeout dut%0d: got no done after %0d cycles, required done", i, n);
        end
    endtask

    initial begin
        int t;
        int e0 [3];
        int w0 [3];
        int d0 [3];
        int lat [3];
        lat = '{2, 1, 4};

        sw_in[0] = '{16'd9, 16'd1, 16'd1, 16'd1};
        sw_in[1] = '{16'd1, 16'd9, 16'd1, 16'd1};
        sw_in[2] = '{16'd1, 16'd1, 16'd9, 16'd1};
        sw_in[3] = '{16'd1, 16'd1, 16'd1, 16'd9};
        sw_in[4] = '{16'hFFF9, 16'hFFFD, 16'hFFF7, 16'hFFFC};
        sw_in[5] = '{16'h8000, 16'h8000, 16'h7FFF, 16'h8000};
        sw_in[6] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
        sw_in[7] = '{16'd5, 16'd5, 16'd5, 16'd5};
`ifdef MAXPOOL_RELU_EN
        sw_exp = '{16'd9, 16'd9, 16'd9, 16'd9, 16'h0000, 16'h7FFF, 16'h0000, 16'd5};
`else
        sw_exp = '{16'd9, 16'd9, 16'd9, 16'd9, 16'hFFFD, 16'h7FFF, 16'h8000, 16'd5};
`endif

        fill_ramp(0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check("reset_in_en",    32'(mp0.in_en), 0);
        check("reset_out_we",   32'(mp0.out_we), 0);
        check("reset_done",     32'(mp0.done), 0);
        check("reset_busy",     32'(mp0.busy), 0);
        check("reset_in_addr",  32'(mp0.in_addr), 0);
        check("reset_out_addr", 32'(mp0.out_addr), 0);
        check("reset_out_d",    32'(mp0.out_d), 0);

        // Ramp on all three latencies at once.
        for (int i = 0; i < 3; i++) begin
            push_ramp(i, 8, 0);
            e0[i] = en_cnt[i];
            w0[i] = we_cnt[i];
        end
        pulse(1'b1, 1'b1, t);
        check("busy_after_start", 32'(mp0.busy), 1);
        for (int i = 0; i < 3; i++) wait_done(i, 0);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("ramp_done_cycle_lat%0d", lat[i]), 32'(done_cyc[i]), 32'(t + N * (5 + lat[i]) + 1));
            check($sformatf("ramp_in_en_count_lat%0d", lat[i]), 32'(en_cnt[i] - e0[i]), 32);
            check($sformatf("ramp_out_we_count_lat%0d", lat[i]), 32'(we_cnt[i] - w0[i]), 8);
        end
        check("ramp_busy_idle", 32'(mp0.busy), 0);
        check("ramp_q0_empty", 32'(exp_q0.size()), 0);
        check("ramp_q1_empty", 32'(exp_q1.size()), 0);
        check("ramp_q2_empty", 32'(exp_q2.size()), 0);

        // Max position sweep and extreme values, one pattern per window.
        for (int w = 0; w < 8; w++) begin
            set_win(w, sw_in[w][0], sw_in[w][1], sw_in[w][2], sw_in[w][3]);
            push(0, 3'(w), sw_exp[w]);
        end
        d0[0] = done_cnt[0];
        pulse(1'b1, 1'b0, t);
        wait_done(0, d0[0]);
        check("sweep_done_cycle", 32'(done_cyc[0]), 32'(t + N * 7 + 1));
        check("sweep_q0_empty", 32'(exp_q0.size()), 0);

        // Start pulsed mid-run must be ignored.
        fill_ramp(0);
        push_ramp(0, 8, 0);
        e0[0] = en_cnt[0];
        w0[0] = we_cnt[0];
        d0[0] = done_cnt[0];
        pulse(1'b1, 1'b0, t);
        repeat (3 * 7) @(posedge clk);
        #1;
        start_m = 1'b1;
        @(posedge clk);
        #1;
        start_m = 1'b0;
        wait_done(0, d0[0]);
        repeat (10) @(posedge clk);
        #1;
        check("ctrl_out_we_count", 32'(we_cnt[0] - w0[0]), 8);
        check("ctrl_in_en_count", 32'(en_cnt[0] - e0[0]), 32);
        check("ctrl_done_count", 32'(done_cnt[0] - d0[0]), 1);

        // Reset during window 5, then a fresh run with new data.
        push_ramp(0, 5, 0);
        w0[0] = we_cnt[0];
        d0[0] = done_cnt[0];
        pulse(1'b1, 1'b0, t);
        repeat (39) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_busy", 32'(mp0.busy), 0);
        check("rst_out_we", 32'(mp0.out_we), 0);
        check("rst_pre_writes", 32'(we_cnt[0] - w0[0]), 5);
        check("rst_q0_empty", 32'(exp_q0.size()), 0);
        fill_ramp(100);
        push_ramp(0, 8, 100);
        pulse(1'b1, 1'b0, t);
        wait_done(0, d0[0]);
        repeat (5) @(posedge clk);
        #1;
        check("rst_done_count", 32'(done_cnt[0] - d0[0]), 1);
        check("rst_done_cycle", 32'(done_cyc[0]), 32'(t + N * 7 + 1));
        check("rst_total_writes", 32'(we_cnt[0] - w0[0]), 13);
        check("final_q0_empty", 32'(exp_q0.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/maxpool_flatten.md
Name: maxpool_flatten

Overview:
- Stage directly upstream of the fully-connected layer.
- Reads the conv feature-map buffer through a LAT-latency BRAM read port and computes a 2x2/stride-2 signed max-pool per channel.
- Writes results, flattened channel-major, into the dense-layer input buffer, then pulses done so the controller can start the dense stage.
- With defaults (8ch x 28x28) it produces 1568 words, matching the FC1 input dimension.

Parameters:
- DATA_WIDTH, 16, signed sample width (Q-format is passed through unchanged)
- CHANNELS, 8, number of feature-map channels
- IN_H, 28, input rows per channel
- IN_W, 28, input columns per channel
- LAT, 2, read latency in cycles from in_en high to in_q valid (legal range 1..4)

Ports:
- clk  in  1  clock
- reset  in  1  reset; synchronous, active-high
- start  in  1  one-cycle start request, sampled only in IDLE
- in_addr  out  $clog2(CHANNELS*IN_H*IN_W)  feature-map read address
- in_en  out  1  feature-map read enable
- in_q  in  DATA_WIDTH  signed read data, valid LAT cycles after the in_en cycle
- out_addr  out  $clog2(CHANNELS*(IN_H/2)*(IN_W/2))  flattened write address
- out_we  out  1  write strobe, one cycle per pooled value
- out_d  out  DATA_WIDTH  signed pooled value
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset values: in_en=0, out_we=0, done=0, busy=0, in_addr=0, out_addr=0, out_d=0; FSM goes to IDLE; counters cleared; read-valid delay line cleared.
- Geometry: OH=IN_H/2, OW=IN_W/2 (floor). An odd trailing row or column is never read.
- Input address: c*IN_H*IN_W + r*IN_W + col.
- Output address: c*OH*OW + pr*OW + pc.
- Iteration order: c outer, pr middle, pc inner.
- FSM states are IDLE, ISSUE, DRAIN, WRITE, FINISH.
  - IDLE: if start is high, clear counters and go to ISSUE. Otherwise hold.
  - ISSUE (4 cycles, k=0..3): drive in_en=1 with window addresses in order (2pr,2pc), (2pr,2pc+1), (2pr+1,2pc), (2pr+1,2pc+1). Then go to DRAIN.
  - DRAIN (LAT cycles): no reads are issued. Go to WRITE.
  - WRITE (1 cycle): out_we=1, with out_addr and out_d driven from the running max. Advance pc/pr/c. Go to ISSUE, or to FINISH after the last window.
  - FINISH (1 cycle): done=1, then go to IDLE.
- Data capture:
  - A LAT-deep valid/tag delay line tracks in-flight reads.
  - in_q is sampled only when the delay line outputs valid.
  - Tag k=0 loads the running max directly; it is NOT initialised to the minimum value.
  - Tags 1..3 update the running max if in_q > max (signed compare). On ties, the earlier value is kept.
- Timing: start high in IDLE at cycle t.
  - First in_en at cycle t+1.
  - Window n (0-based) asserts out_we at cycle t+(n+1)*(5+LAT).
  - done at cycle t+N*(5+LAT)+1, where N=CHANNELS*OH*OW.
  - busy is low only in IDLE.
- start while busy is ignored; there is no queueing.
- Reset mid-operation: outputs return to reset values the next cycle, and in-flight read data arriving after reset is ignored. A fresh start restarts at window 0.
- No arithmetic is performed other than the compare; no saturation is needed.

Optional Feature:
- MAXPOOL_RELU_EN defined: in WRITE, out_d = (max < 0) ? 0 : max, i.e. a fused ReLU; timing is unchanged.
- Undefined: out_d = max unmodified, so negative values pass through.

Decomposition:
- Shared package cnn_pkg:
  - data_t (signed DATA_WIDTH)
  - S_MAX/S_MIN constants
  - state enum for pool_state_t
  - address-width helper functions (clog2 with a minimum of 1)
- Sub-module maxpool_addr_gen: holds the c/pr/pc/k counters and both address computations. It exposes in_addr, out_addr, last_k and last_window.

Test Plan:
- Ramp, CHANNELS=2, IN_H=IN_W=4, LAT=2, mem[a]=a -> 8 writes at addrs 0..7 with values 5,7,13,15,21,23,29,31; done at t+8*7+1=t+57.
- Max position sweep: one window with {9,1,1,1}, {1,9,1,1}, {1,1,9,1}, {1,1,1,9} -> out_d=9 each time. With {-7,-3,-9,-4} -> -3 when RELU is off, 0 with MAXPOOL_RELU_EN.
- Extremes: window {0x8000,0x8000,0x7FFF,0x8000} -> 0x7FFF. Window {0x8000 x4} -> 0x8000, confirming no min-init bias.
- Latency sweep: repeat the ramp test with LAT=1 and LAT=4 -> identical data. done at t+8*6+1 and t+8*9+1. in_en asserted exactly 32 cycles; out_we exactly 8 cycles.
- Control: start pulsed at window 3 -> ignored, write count stays 8.
- Reset at window 5, then a new start -> writes restart at out_addr 0 with correct values, and no spurious out_we or done from pre-reset reads.
